player_grid_mover: RTL and testbench

Grid-based player controller for the arcade game datapath: it turns four direction switches into tile-quantised moves with press-then-auto-repeat timing, and tracks score, lives, respawn blanking and game over. It sits between the switch inputs, the collision detector and the sprite renderer. It generalises the earlier single-life frog controller to any grid size and start tile, and adds hold-to-repeat, a life counter, a respawn window and a restart handshake.

---
 rtl/player_pkg.sv | 50 +++++
 rtl/player_grid_mover_dir_repeat.sv | 88 ++++++++
 rtl/player_grid_mover.sv | 175 +++++++++++++++++
 tb/tb_player_grid_mover.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// player_pkg: shared types for the grid player controller.
//   state_t : controller states (IDLE/HOLD/REPEAT live in the repeat timer,
//             IDLE/DEAD/GAME_OVER in the top-level life control)
//   dir_t   : 2-bit direction code
//   qdir_t  : qualified direction = code plus a NONE flag
//   is_one_hot / qualify : switch qualification helpers
package player_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD      = 3'd1,
        ST_REPEAT    = 3'd2,
        ST_DEAD      = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP = 2'd0,
        DIR_DN = 2'd1,
        DIR_LT = 2'd2,
        DIR_RT = 2'd3
    } dir_t;

    typedef struct packed {
        logic none;
        dir_t code;
    } qdir_t;

    localparam qdir_t QDIR_NONE = '{none: 1'b1, code: DIR_UP};

    // Switch vector order is {up, dn, lt, rt}.
    function automatic logic is_one_hot(input logic [3:0] sw);
        return (sw != 4'd0) && ((sw & (sw - 4'd1)) == 4'd0);
    endfunction

    // Zero or several switches high means no direction at all.
    function automatic qdir_t qualify(input logic [3:0] sw);
        qdir_t q;
        q = QDIR_NONE;
        if (is_one_hot(sw)) begin
            q.none = 1'b0;
            if (sw[3])      q.code = DIR_UP;
            else if (sw[2]) q.code = DIR_DN;
            else if (sw[1]) q.code = DIR_LT;
            else            q.code = DIR_RT;
        end
        return q;
    endfunction

endpackage

// File: rtl/player_grid_mover_dir_repeat.sv
// dir_repeat: direction qualification, fresh-press detection and the
// press-then-auto-repeat timer.
//   clk, rst      : clock, asynchronous active-high reset
//   en            : high while the player is alive; low clears all history
//   up, dn, lt, rt: synchronised direction switches
//   step          : combinational single-cycle move strobe
//   step_dir      : direction of the move requested by step
module dir_repeat
    import player_pkg::*;
#(
    parameter int REPEAT_DELAY = 12500000,
    parameter int STEP_PERIOD  = 3125000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic up,
    input  logic dn,
    input  logic lt,
    input  logic rt,
    output logic step,
    output dir_t step_dir
);

    localparam int CNT_MAX = (REPEAT_DELAY > STEP_PERIOD) ? REPEAT_DELAY : STEP_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(STEP_PERIOD - 1);

    qdir_t            cur;
    qdir_t            prev;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             fresh;
    logic             expired;

    assign cur   = qualify({up, dn, lt, rt});
    assign fresh = !cur.none && (prev.none || (prev.code != cur.code));

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        expired = 1'b0;
        case (state)
            ST_HOLD:   expired = (cnt == DELAY_LAST);
            ST_REPEAT: expired = (cnt == PERIOD_LAST);
            default:   expired = 1'b0;
        endcase
    end

    // A non-fresh valid direction can only be the one being held, so expiry
    // alone is enough to fire a repeat.
    assign step     = en && !cur.none && (fresh || expired);
    assign step_dir = cur.code;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: timers are reset too; an unreset counter could fire a spurious
    // repeat right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            prev  <= QDIR_NONE;
        end else if (!en) begin
            // Clearing history makes a switch held across the respawn count
            // as a fresh press once the player is back.
            state <= ST_IDLE;
            cnt   <= '0;
            prev  <= QDIR_NONE;
        end else begin
            prev <= cur;
            if (cur.none) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (fresh) begin
                state <= ST_HOLD;
                cnt   <= '0;
            end else if (expired) begin
                state <= ST_REPEAT;
                cnt   <= '0;
            end else if (state != ST_IDLE) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/player_grid_mover.sv
// player_grid_mover: tile-quantised player controller with auto-repeat,
// score, lives, respawn blanking and game over.
//   i_Clk, i_Rst          : clock, asynchronous active-high reset
//   i_Up/i_Dn/i_Lt/i_Rt   : synchronised direction switches
//   i_Has_Collided        : level, player overlaps a hazard
//   i_Restart             : pulse, honoured only in game over
//   o_Col/o_Row           : current tile; o_Pos_X/o_Pos_Y its pixel top-left
//   o_Score/o_Lives       : goals reached / lives remaining
//   o_Draw_Player         : sprite enable
//   o_Moved/o_Scored      : one-cycle pulses per accepted move / goal
//   o_Game_Over           : level, high while the game is over
module player_grid_mover
    import player_pkg::*;
#(
    parameter int TILE_SIZE      = 32,
    parameter int GRID_COLS      = 20,
    parameter int GRID_ROWS      = 15,
    parameter int START_COL      = 10,
    parameter int START_ROW      = 12,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int STEP_PERIOD    = 3125000,
    parameter int RESPAWN_CYCLES = 25000000,
    parameter int LIVES_INI      = 3,
    parameter int SCORE_W        = 7
) (
    input  logic                             i_Clk,
    input  logic                             i_Rst,
    input  logic                             i_Up,
    input  logic                             i_Dn,
    input  logic                             i_Lt,
    input  logic                             i_Rt,
    input  logic                             i_Has_Collided,
    input  logic                             i_Restart,
    output logic [$clog2(GRID_COLS)-1:0]     o_Col,
    output logic [$clog2(GRID_ROWS)-1:0]     o_Row,
    output logic [9:0]                       o_Pos_X,
    output logic [9:0]                       o_Pos_Y,
    output logic [SCORE_W-1:0]               o_Score,
    output logic [$clog2(LIVES_INI+1)-1:0]   o_Lives,
    output logic                             o_Draw_Player,
    output logic                             o_Moved,
    output logic                             o_Scored,
    output logic                             o_Game_Over
);

    localparam int COL_W   = $clog2(GRID_COLS);
    localparam int ROW_W   = $clog2(GRID_ROWS);
    localparam int LIVES_W = $clog2(LIVES_INI + 1);
    localparam int TILE_SH = $clog2(TILE_SIZE);
    localparam int RSP_W   = $clog2(RESPAWN_CYCLES + 1);

    localparam logic [COL_W-1:0]   START_C    = COL_W'(START_COL);
    localparam logic [ROW_W-1:0]   START_R    = ROW_W'(START_ROW);
    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(GRID_COLS - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(GRID_ROWS - 1);
    localparam logic [LIVES_W-1:0] LIVES_FULL = LIVES_W'(LIVES_INI);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [RSP_W-1:0]   RSP_LAST   = RSP_W'(RESPAWN_CYCLES - 1);

    state_t           state;
    logic [RSP_W-1:0] rsp_cnt;
    logic             alive;
    logic             step;
    dir_t             step_dir;
    logic             move_ok;
    logic             goal;
    logic [COL_W-1:0] next_col;
    logic [ROW_W-1:0] next_row;

    assign alive = (state == ST_IDLE);

    dir_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .STEP_PERIOD  (STEP_PERIOD)
    ) u_dir_repeat (
        .clk      (i_Clk),
        .rst      (i_Rst),
        .en       (alive),
        .up       (i_Up),
        .dn       (i_Dn),
        .lt       (i_Lt),
        .rt       (i_Rt),
        .step     (step),
        .step_dir (step_dir)
    );

    // Edge check and next tile for the requested direction.
    always_comb begin
        move_ok  = 1'b0;
        next_col = o_Col;
        next_row = o_Row;
        case (step_dir)
            DIR_UP: if (o_Row != '0)       begin move_ok = 1'b1; next_row = o_Row - ROW_W'(1); end
            DIR_DN: if (o_Row != LAST_ROW) begin move_ok = 1'b1; next_row = o_Row + ROW_W'(1); end
            DIR_LT: if (o_Col != '0)       begin move_ok = 1'b1; next_col = o_Col - COL_W'(1); end
            DIR_RT: if (o_Col != LAST_COL) begin move_ok = 1'b1; next_col = o_Col + COL_W'(1); end
            default: move_ok = 1'b0;
        endcase
    end

    assign goal = (step_dir == DIR_UP) && (o_Row == ROW_W'(1));

    // Pixel coordinates are pure shifts of the registered tile, so they can
    // never disagree with o_Col/o_Row.
    assign o_Pos_X = 10'(o_Col) << TILE_SH;
    assign o_Pos_Y = 10'(o_Row) << TILE_SH;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state         <= ST_IDLE;
            rsp_cnt       <= '0;
            o_Col         <= START_C;
            o_Row         <= START_R;
            o_Score       <= '0;
            o_Lives       <= LIVES_FULL;
            o_Draw_Player <= 1'b1;
            o_Moved       <= 1'b0;
            o_Scored      <= 1'b0;
            o_Game_Over   <= 1'b0;
        end else begin
            o_Moved  <= 1'b0;
            o_Scored <= 1'b0;
            case (state)
                ST_DEAD: begin
                    if (rsp_cnt == RSP_LAST) begin
                        state         <= ST_IDLE;
                        rsp_cnt       <= '0;
                        o_Draw_Player <= 1'b1;
                    end else begin
                        rsp_cnt <= rsp_cnt + RSP_W'(1);
                    end
                end
                ST_GAME_OVER: begin
                    if (i_Restart) begin
                        state       <= ST_DEAD;
                        rsp_cnt     <= '0;
                        o_Lives     <= LIVES_FULL;
                        o_Score     <= '0;
                        o_Col       <= START_C;
                        o_Row       <= START_R;
                        o_Game_Over <= 1'b0;
                    end
                end
                default: begin
                    // Collision outranks any move requested in the same cycle.
                    if (i_Has_Collided) begin
                        o_Lives       <= o_Lives - LIVES_W'(1);
                        o_Col         <= START_C;
                        o_Row         <= START_R;
                        o_Draw_Player <= 1'b0;
                        rsp_cnt       <= '0;
                        if (o_Lives == LIVES_W'(1)) begin
                            state       <= ST_GAME_OVER;
                            o_Game_Over <= 1'b1;
                        end else begin
                            state <= ST_DEAD;
                        end
                    end else if (step && move_ok) begin
                        o_Moved <= 1'b1;
                        if (goal) begin
                            o_Scored <= 1'b1;
                            o_Col    <= START_C;
                            o_Row    <= START_R;
                            if (o_Score != SCORE_MAX) o_Score <= o_Score + SCORE_W'(1);
                        end else begin
                            o_Col <= next_col;
                            o_Row <= next_row;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_grid_mover.sv
// Scoreboard bench for player_grid_mover: each move expected from the
// stimulus is queued with the cycle it should appear on; a monitor pops and
// compares on every o_Moved pulse. Small timing parameters keep runs short;
// SCORE_W=2 lets the score saturate after four goals.
module tb_player_grid_mover;

    localparam int RD  = 8;
    localparam int SP  = 4;
    localparam int RSP = 10;

    localparam logic [3:0] M_UP = 4'b1000;
    localparam logic [3:0] M_DN = 4'b0100;
    localparam logic [3:0] M_LT = 4'b0010;
    localparam logic [3:0] M_RT = 4'b0001;

    logic       clk = 1'b0;
    logic       rst;
    logic       up, dn, lt, rt;
    logic       coll, restart;
    logic [4:0] col;
    logic [3:0] row;
    logic [9:0] px, py;
    logic [1:0] score;
    logic [1:0] lives;
    logic       draw, moved, scored, go;

    player_grid_mover #(
        .TILE_SIZE      (32),
        .GRID_COLS      (20),
        .GRID_ROWS      (15),
        .START_COL      (10),
        .START_ROW      (12),
        .REPEAT_DELAY   (RD),
        .STEP_PERIOD    (SP),
        .RESPAWN_CYCLES (RSP),
        .LIVES_INI      (3),
        .SCORE_W        (2)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Up           (up),
        .i_Dn           (dn),
        .i_Lt           (lt),
        .i_Rt           (rt),
        .i_Has_Collided (coll),
        .i_Restart      (restart),
        .o_Col          (col),
        .o_Row          (row),
        .o_Pos_X        (px),
        .o_Pos_Y        (py),
        .o_Score        (score),
        .o_Lives        (lives),
        .o_Draw_Player  (draw),
        .o_Moved        (moved),
        .o_Scored       (scored),
        .o_Game_Over    (go)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int col;
        int row;
        int score;
        bit scored;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c, input int cl, input int rw, input int sc, input bit s);
        exp_t e;
        e.cyc = c; e.col = cl; e.row = rw; e.score = sc; e.scored = s;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] m);
        {up, dn, lt, rt} = m;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_col"},   int'(col),   10);
        check({tag, "_row"},   int'(row),   12);
        check({tag, "_pos_x"}, int'(px),    320);
        check({tag, "_pos_y"}, int'(py),    384);
        check({tag, "_score"}, int'(score), 0);
        check({tag, "_lives"}, int'(lives), 3);
        check({tag, "_draw"},  int'(draw),  1);
        check({tag, "_moved"}, int'(moved), 0);
        check({tag, "_scored"},int'(scored),0);
        check({tag, "_go"},    int'(go),    0);
    endtask

    // Monitor: every move pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (moved) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_move: cycle %0d col %0d row %0d", cyc, col, row);
                end else begin
                    mon_e = sb.pop_front();
                    if (cyc != mon_e.cyc || int'(col) != mon_e.col || int'(row) != mon_e.row ||
                        int'(px) != mon_e.col * 32 || int'(py) != mon_e.row * 32 ||
                        int'(score) != mon_e.score || scored != mon_e.scored) begin
                        fails++;
                        $display("FAIL move: got cyc %0d col %0d row %0d x %0d y %0d score %0d scored %0d, expected cyc %0d col %0d row %0d x %0d y %0d score %0d scored %0d",
                                 cyc, col, row, px, py, score, scored,
                                 mon_e.cyc, mon_e.col, mon_e.row, mon_e.col * 32, mon_e.row * 32,
                                 mon_e.score, mon_e.scored);
                    end
                end
            end else if (scored) begin
                tests++;
                fails++;
                $display("FAIL scored_without_move: cycle %0d", cyc);
            end
        end
    end

    initial begin
        int c;
        int k;
        int sc;
        bit g;

        rst = 1'b1; coll = 1'b0; restart = 1'b0;
        drive(4'b0000);
        tick(3);
        rst = 1'b0;
        tick(1);
        check_reset_values("reset");

        // Single-cycle Rt press, then an invalid Up+Lt combination.
        push(cyc + 1, 11, 12, 0, 1'b0);
        drive(M_RT);
        tick(1);
        drive(4'b0000);
        check("pos_x_after_rt", int'(px), 352);
        drive(M_UP | M_LT);
        tick(3);
        drive(4'b0000);
        tick(2);
        check("col_after_up_lt", int'(col), 11);

        // Hold Lt 20 cycles: moves at +1, +9, +13, +17.
        c = cyc;
        push(c + 1,  10, 12, 0, 1'b0);
        push(c + 9,   9, 12, 0, 1'b0);
        push(c + 13,  8, 12, 0, 1'b0);
        push(c + 17,  7, 12, 0, 1'b0);
        drive(M_LT);
        tick(20);
        drive(4'b0000);
        tick(10);
        check("col_after_repeat", int'(col), 7);

        // Auto-repeat Rt into the right edge; further attempts are blocked.
        c = cyc;
        for (int m = 0; m < 12; m++) begin
            k = (m == 0) ? 0 : RD + SP * (m - 1);
            push(c + 1 + k, 8 + m, 12, 0, 1'b0);
        end
        drive(M_RT);
        tick(60);
        drive(4'b0000);
        tick(3);
        drive(M_RT);
        tick(1);
        drive(4'b0000);
        tick(2);
        check("col_at_right_edge", int'(col), 19);

        // Hold Up through four goals; score saturates at 3.
        c = cyc;
        for (int m = 0; m < 48; m++) begin
            k  = (m == 0) ? 0 : RD + SP * (m - 1);
            g  = ((m % 12) == 11);
            sc = (m + 1) / 12;
            if (sc > 3) sc = 3;
            push(c + 1 + k, (m < 11) ? 19 : 10, g ? 12 : 11 - (m % 12), sc, g);
        end
        drive(M_UP);
        tick(193);
        drive(4'b0000);
        tick(3);
        check("score_saturated", int'(score), 3);

        // Collision and a fresh press in the same cycle: collision wins.
        push(cyc + 1, 9, 12, 3, 1'b0);
        drive(M_LT);
        tick(1);
        drive(4'b0000);
        tick(2);
        c = cyc;
        drive(M_RT);
        coll = 1'b1;
        tick(1);
        coll = 1'b0;
        drive(M_UP);
        check("lives_after_hit", int'(lives), 2);
        check("draw_after_hit",  int'(draw),  0);
        check("col_after_hit",   int'(col),   10);
        check("go_after_hit",    int'(go),    0);
        // Collisions while dead are ignored; Up held across respawn moves once back.
        coll = 1'b1;
        tick(3);
        coll = 1'b0;
        push(c + RSP + 2, 10, 11, 3, 1'b0);
        tick(RSP - 4);
        check("draw_low_end_dead", int'(draw),  0);
        check("lives_dead_hits",   int'(lives), 2);
        tick(1);
        check("draw_after_respawn", int'(draw), 1);
        tick(1);
        drive(4'b0000);
        tick(3);

        // Second and third collisions lead to game over; restart recovers.
        coll = 1'b1;
        tick(1);
        coll = 1'b0;
        check("lives_second_hit", int'(lives), 1);
        tick(RSP + 3);
        coll = 1'b1;
        tick(1);
        coll = 1'b0;
        check("lives_third_hit", int'(lives), 0);
        check("go_third_hit",    int'(go),    1);
        check("draw_game_over",  int'(draw),  0);
        drive(M_RT);
        tick(5);
        drive(4'b0000);
        check("go_holds", int'(go), 1);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("lives_restart", int'(lives), 3);
        check("score_restart", int'(score), 0);
        check("go_restart",    int'(go),    0);
        check("draw_restart",  int'(draw),  0);
        check("col_restart",   int'(col),   10);
        tick(RSP);
        check("draw_after_restart", int'(draw), 1);

        // Asynchronous reset in the middle of auto-repeat.
        c = cyc;
        push(c + 1,  9, 12, 0, 1'b0);
        push(c + 9,  8, 12, 0, 1'b0);
        push(c + 13, 7, 12, 0, 1'b0);
        drive(M_LT);
        tick(14);
        #1 rst = 1'b1;
        #1 check_reset_values("mid_repeat_reset");
        drive(4'b0000);
        tick(2);
        rst = 1'b0;
        tick(2);
        check("col_after_reset_release", int'(col), 10);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
